stream_slice_pipe: RTL and testbench
====================================

STREAM_SLICE_PIPE -- requirements
Module: stream_slice_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning payload width in bits (1..1024).
REQ-002 The block SHALL have parameter STAGES, default 2, meaning the number of cascaded slice stages (1..8).
REQ-003 The block SHALL have parameter MODE, default 7, meaning 0 none, 1 forward, 2 reverse, 3 lite both ways, 7 high-performance both ways; other values SHALL be an elaboration $fatal.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 The block SHALL have port flush, input, 1, a synchronous discard of all held beats.
REQ-007 The block SHALL have the ports w_valid/w_ready/w_data, input/output/input, 1/1/DATA_WIDTH, forming the upstream handshake.
REQ-008 The block SHALL have the ports r_valid/r_ready/r_data, output/input/output, 1/1/DATA_WIDTH, forming the downstream handshake.
REQ-009 The block SHALL have port level, output, $clog2(2*STAGES+1), the number of beats held; it exists only under REQ-024.

Function
REQ-010 A transfer SHALL occur on a side when valid and ready are both high at a clock edge; beats SHALL leave in arrival order, with none lost or duplicated.
REQ-011 Once r_valid is asserted, r_valid and r_data SHALL hold until r_ready is seen, except on rst or flush.
REQ-012 MODE 0 SHALL be pure wires (r_*=w_*, w_ready=r_ready), STAGES SHALL be ignored, and level SHALL be 0.
REQ-013 In MODE 1 each stage SHALL hold 1 entry with r_valid/r_data registered; w_ready = !full || r_ready (combinational); latency is STAGES cycles; throughput is 1 beat/cycle.
REQ-014 In MODE 2 each stage SHALL hold 1 skid entry with w_ready registered (= skid empty); data SHALL pass combinationally when the skid is empty (latency 0) and come from the skid otherwise.
REQ-015 In MODE 3 each stage SHALL hold 1 entry with all outputs registered; w_ready = entry empty; throughput is 1 beat per 2 cycles; latency is STAGES cycles.
REQ-016 In MODE 7 each stage SHALL be a 2-entry FSM (EMPTY, ONE, TWO) with all outputs registered and w_ready = (state != TWO).
REQ-017 MODE 7 transitions SHALL be: EMPTY--push-->ONE; ONE--push&!pop-->TWO; ONE--pop&!push-->EMPTY; ONE--push&pop-->ONE; TWO--pop-->ONE. Latency is STAGES cycles and sustained throughput is 1 beat/cycle.
REQ-018 level SHALL be incremented on an upstream transfer and decremented on a downstream transfer, SHALL be unchanged when both occur, and SHALL never exceed STAGES*capacity (capacity 2 in MODE 7, otherwise 1).
REQ-019 While flush is high, w_ready SHALL be 0; at the edge, all entries SHALL be emptied, level SHALL become 0, and r_valid SHALL become 0 from the next cycle; a downstream transfer in the flush cycle SHALL still complete.
REQ-020 Simultaneous rst and flush SHALL behave as rst.

Reset
REQ-021 On rst, all stages SHALL go to EMPTY, and r_valid=0 and level=0 at the next edge.
REQ-022 w_ready SHALL be 0 during rst and SHALL be 1 in the first cycle after rst deasserts (MODE 0: follows r_ready).
REQ-023 Data registers SHALL not be reset; rst mid-burst SHALL drop held beats without emitting partial data.

Configuration
REQ-024 With STREAM_SLICE_PIPE_LEVEL_EN defined, the level port and its counter SHALL be present per REQ-018; without it, neither the port nor the counter SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-025 Package stream_slice_pkg SHALL hold the MODE constants (MODE_NONE=0, MODE_FWD=1, MODE_REV=2, MODE_LITE=3, MODE_FULL=7), the stage-state enum (EMPTY/ONE/TWO), and the function computing level width.
REQ-026 One sub-module, stream_slice_stage (parameters DATA_WIDTH, MODE), SHALL implement a single stage; stream_slice_pipe SHALL chain STAGES instances with a generate loop.

Verification
REQ-027 MODE 7, STAGES=2, r_ready=1, send 0x1..0x10 back-to-back -> 0x1 out at cycle 2, then one beat per cycle, all in order.
REQ-028 MODE 7, STAGES=2, r_ready=0, stream beats -> exactly 4 accepted, w_ready=0 after the 4th, level=4; raising r_ready drains 4 beats in order.
REQ-029 MODE 3, STAGES=1, r_ready=1, w_valid=1 continuously -> w_ready toggles and 1 beat is delivered every 2 cycles.
REQ-030 MODE 2, STAGES=1, r_ready=1 -> r_data equals w_data in the same cycle; one cycle of r_ready=0 -> 1 beat is captured in the skid and w_ready=0 the next cycle.
REQ-031 MODE 7, with 3 beats held, pulse flush -> r_valid=0 and level=0 the next cycle; the next beat 0xA5 is delivered in the normal STAGES cycles.
REQ-032 Random valid/ready at 50% with MODE 1/3/7 and STAGES 1..8 and rst pulsed mid-stream -> the scoreboard shows no loss, duplication or reorder, and r_valid is stable until taken.

Source files
------------

// File: rtl/stream_slice_pkg.sv
// stream_slice_pkg
//   Shared definitions for the stream slice pipeline:
//   - MODE_* constants selecting the slice flavour of every stage
//   - stage_state_e, the occupancy state of one stage
//   - level_width(), the width of the optional occupancy counter
//   - mode_supported(), used to reject unknown MODE values at elaboration

package stream_slice_pkg;

    localparam int MODE_NONE = 0;
    localparam int MODE_FWD  = 1;
    localparam int MODE_REV  = 2;
    localparam int MODE_LITE = 3;
    localparam int MODE_FULL = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    // Wide enough for 0 .. 2*stages (MODE_FULL holds two beats per stage).
    function automatic int level_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

    function automatic bit mode_supported(input int mode);
        return (mode == MODE_NONE) || (mode == MODE_FWD) || (mode == MODE_REV) ||
               (mode == MODE_LITE) || (mode == MODE_FULL);
    endfunction

endpackage

// File: rtl/stream_slice_stage.sv
// stream_slice_stage
//   One valid/ready register slice. MODE selects the flavour:
//     MODE_FWD  : 1 entry, r_valid/r_data registered, w_ready = !full || r_ready
//     MODE_REV  : 1 skid entry, w_ready registered (= skid empty),
//                 data passes straight through while the skid is empty
//     MODE_LITE : 1 entry, all outputs registered, half throughput
//     MODE_FULL : 2 entries, all outputs registered, full throughput
//
//   state | meaning
//   ------+------------------------------------------------------------
//   EMPTY | no beat held
//   ONE   | one beat held in head_q (skid beat for MODE_REV)
//   TWO   | MODE_FULL only: head_q presented downstream, tail_q waiting
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   flush             : synchronous discard of the held beats
//   w_valid/w_ready/w_data : upstream handshake
//   r_valid/r_ready/r_data : downstream handshake

module stream_slice_stage
    import stream_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MODE       = MODE_FULL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_data
);

    stage_state_e          state_q;
    stage_state_e          state_d;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic                  load_head;
    logic                  load_tail;
    logic                  head_from_tail;
    logic                  push;
    logic                  pop;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers carry no reset; the state register alone decides
    // whether their contents are meaningful.
    always_ff @(posedge clk) begin
        if (load_head) begin
            head_q <= w_data;
        end else if (head_from_tail) begin
            head_q <= tail_q;
        end
        if (load_tail) begin
            tail_q <= w_data;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        w_ready        = 1'b0;
        r_valid        = (state_q != EMPTY);
        r_data         = head_q;

        case (MODE)
            MODE_FWD: begin
                w_ready = (state_q == EMPTY) || r_ready;
                push    = w_valid && w_ready;
                pop     = r_valid && r_ready;
                if (push) begin
                    load_head = 1'b1;
                    state_d   = ONE;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end

            MODE_REV: begin
                w_ready = (state_q == EMPTY);
                if (state_q == EMPTY) begin
                    // The pass-through path is blocked during rst/flush so a
                    // beat the upstream side never handed over cannot leak out.
                    r_valid = w_valid && !rst && !flush;
                    r_data  = w_data;
                    if (w_valid && !r_ready) begin
                        load_head = 1'b1;
                        state_d   = ONE;
                    end
                end else if (r_ready) begin
                    state_d = EMPTY;
                end
            end

            MODE_LITE: begin
                w_ready = (state_q == EMPTY);
                if (state_q == EMPTY) begin
                    if (w_valid) begin
                        load_head = 1'b1;
                        state_d   = ONE;
                    end
                end else if (r_ready) begin
                    state_d = EMPTY;
                end
            end

            MODE_FULL: begin
                w_ready = (state_q != TWO);
                push    = w_valid && w_ready;
                pop     = r_valid && r_ready;
                case (state_q)
                    EMPTY: begin
                        if (push) begin
                            load_head = 1'b1;
                            state_d   = ONE;
                        end
                    end
                    ONE: begin
                        if (push && !pop) begin
                            load_tail = 1'b1;
                            state_d   = TWO;
                        end else if (pop && !push) begin
                            state_d = EMPTY;
                        end else if (push && pop) begin
                            load_head = 1'b1;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            head_from_tail = 1'b1;
                            state_d        = ONE;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                    end
                endcase
            end

            default: begin
            end
        endcase
    end

endmodule

// File: rtl/stream_slice_pipe.sv
// stream_slice_pipe
//   Chain of STAGES stream_slice_stage instances between an upstream and a
//   downstream valid/ready interface. MODE_NONE degenerates to plain wires.
//
// Parameters
//   DATA_WIDTH : payload width (1..1024)
//   STAGES     : number of cascaded slices (1..8), ignored for MODE_NONE
//   MODE       : 0 none, 1 forward, 2 reverse, 3 lite, 7 full
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   flush             : synchronous discard of all held beats
//   w_valid/w_ready/w_data : upstream handshake
//   r_valid/r_ready/r_data : downstream handshake
//   level             : beats held; present only when
//                       STREAM_SLICE_PIPE_LEVEL_EN is defined

module stream_slice_pipe
    import stream_slice_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2,
    parameter int MODE       = MODE_FULL
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [DATA_WIDTH-1:0]            w_data,
    output logic                             r_valid,
    input  logic                             r_ready,
    output logic [DATA_WIDTH-1:0]            r_data
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
    ,
    output logic [level_width(STAGES)-1:0]   level
`endif
);

    if (!mode_supported(MODE)) begin : g_bad_mode
        $fatal(1, "stream_slice_pipe: unsupported MODE %0d", MODE);
    end

    if ((DATA_WIDTH < 1) || (DATA_WIDTH > 1024) || (STAGES < 1) || (STAGES > 8)) begin : g_bad_size
        $fatal(1, "stream_slice_pipe: DATA_WIDTH %0d / STAGES %0d out of range",
               DATA_WIDTH, STAGES);
    end

    if (MODE == MODE_NONE) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, flush};
        assign r_valid     = w_valid;
        assign r_data      = w_data;
        assign w_ready     = r_ready;
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        assign level       = '0;
`endif
    end else begin : g_chain
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            logic                  in_valid;
            logic                  in_ready;
            logic [DATA_WIDTH-1:0] in_data;
            logic                  out_valid;
            logic                  out_ready;
            logic [DATA_WIDTH-1:0] out_data;

            if (i == 0) begin : g_head
                assign in_valid = w_valid;
                assign in_data  = w_data;
            end else begin : g_link
                assign in_valid = g_stage[i-1].out_valid;
                assign in_data  = g_stage[i-1].out_data;
            end

            if (i == STAGES - 1) begin : g_tail
                assign out_ready = r_ready;
            end else begin : g_back
                assign out_ready = g_stage[i+1].in_ready;
            end

            stream_slice_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .MODE       (MODE)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .w_valid (in_valid),
                .w_ready (in_ready),
                .w_data  (in_data),
                .r_valid (out_valid),
                .r_ready (out_ready),
                .r_data  (out_data)
            );
        end

        // The first stage is already empty in the cycle after rst, so only
        // the live rst/flush inputs have to hold w_ready low.
        assign w_ready = g_stage[0].in_ready && !rst && !flush;
        assign r_valid = g_stage[STAGES-1].out_valid;
        assign r_data  = g_stage[STAGES-1].out_data;

`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        localparam int LW = level_width(STAGES);

        logic [LW-1:0] level_q;
        logic          up_xfer;
        logic          dn_xfer;

        assign up_xfer = w_valid && w_ready;
        assign dn_xfer = r_valid && r_ready;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                level_q <= '0;
            end else if (up_xfer && !dn_xfer) begin
                level_q <= level_q + LW'(1);
            end else if (dn_xfer && !up_xfer) begin
                level_q <= level_q - LW'(1);
            end
        end

        assign level = level_q;
`endif
    end

endmodule

// File: tb/tb_stream_slice_pipe.sv
// tb_stream_slice_pipe
//   Directed checks on MODE 7/3/2/0 instances plus randomized traffic with a
//   scoreboard on several MODE/STAGES combinations. Level checks are compiled
//   in only when STREAM_SLICE_PIPE_LEVEL_EN is defined.

module tb_stream_slice_pipe;

    logic clk;
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic rst_d, flush_d;

    logic        s7_w_valid, s7_w_ready, s7_r_valid, s7_r_ready;
    logic [15:0] s7_w_data, s7_r_data;
    logic        s3_w_valid, s3_w_ready, s3_r_valid, s3_r_ready;
    logic [15:0] s3_w_data, s3_r_data;
    logic        s2_w_valid, s2_w_ready, s2_r_valid, s2_r_ready;
    logic [15:0] s2_w_data, s2_r_data;
    logic        s0_w_valid, s0_w_ready, s0_r_valid, s0_r_ready;
    logic [15:0] s0_w_data, s0_r_data;
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
    logic [2:0]  s7_level;
    logic [1:0]  s3_level, s2_level, s0_level;
`endif

    stream_slice_pipe #(.DATA_WIDTH(16), .STAGES(2), .MODE(7)) u_m7 (
        .clk(clk), .rst(rst_d), .flush(flush_d),
        .w_valid(s7_w_valid), .w_ready(s7_w_ready), .w_data(s7_w_data),
        .r_valid(s7_r_valid), .r_ready(s7_r_ready), .r_data(s7_r_data)
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        , .level(s7_level)
`endif
    );

    stream_slice_pipe #(.DATA_WIDTH(16), .STAGES(1), .MODE(3)) u_m3 (
        .clk(clk), .rst(rst_d), .flush(flush_d),
        .w_valid(s3_w_valid), .w_ready(s3_w_ready), .w_data(s3_w_data),
        .r_valid(s3_r_valid), .r_ready(s3_r_ready), .r_data(s3_r_data)
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        , .level(s3_level)
`endif
    );

    stream_slice_pipe #(.DATA_WIDTH(16), .STAGES(1), .MODE(2)) u_m2 (
        .clk(clk), .rst(rst_d), .flush(flush_d),
        .w_valid(s2_w_valid), .w_ready(s2_w_ready), .w_data(s2_w_data),
        .r_valid(s2_r_valid), .r_ready(s2_r_ready), .r_data(s2_r_data)
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        , .level(s2_level)
`endif
    );

    stream_slice_pipe #(.DATA_WIDTH(16), .STAGES(1), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst_d), .flush(flush_d),
        .w_valid(s0_w_valid), .w_ready(s0_w_ready), .w_data(s0_w_data),
        .r_valid(s0_r_valid), .r_ready(s0_r_ready), .r_data(s0_r_data)
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        , .level(s0_level)
`endif
    );

    // Randomized traffic, one independent DUT + scoreboard per configuration.
    localparam int N_RND = 6;
    localparam int RND_MODE [N_RND] = '{1, 1, 3, 7, 7, 2};
    localparam int RND_STG  [N_RND] = '{1, 8, 3, 1, 8, 3};

    for (genvar g = 0; g < N_RND; g++) begin : g_rnd
        localparam int M = RND_MODE[g];
        localparam int S = RND_STG[g];

        logic        rst, flush, w_valid, w_ready, r_valid, r_ready;
        logic [15:0] w_data, r_data;
        bit          done;
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        logic [$clog2(2*S+1)-1:0] level;
`endif

        stream_slice_pipe #(.DATA_WIDTH(16), .STAGES(S), .MODE(M)) u_dut (
            .clk(clk), .rst(rst), .flush(flush),
            .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
            .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
            , .level(level)
`endif
        );

        initial begin : drive
            logic [15:0] q [$];
            logic [15:0] nxt, prev_rd;
            logic        took_w, prev_rv, prev_rr, prev_rst;
            done    = 1'b0;
            rst     = 1'b1;
            flush   = 1'b0;
            w_valid = 1'b0;
            w_data  = '0;
            r_ready = 1'b0;
            nxt     = 16'd1;
            took_w  = 1'b0;
            prev_rv = 1'b0;
            prev_rr = 1'b0;
            prev_rst = 1'b1;
            prev_rd = '0;
            repeat (3) @(negedge clk);
            for (int cyc = 0; cyc < 700; cyc++) begin
                @(negedge clk);
                rst = (cyc == 300) || (cyc == 301);
                if (took_w) nxt = nxt + 16'd1;
                // A presented beat stays until it is taken.
                if (!w_valid || took_w) w_valid = (cyc < 620) && ($urandom_range(0, 1) == 1);
                w_data  = nxt;
                r_ready = !rst && ((cyc >= 620) || ($urandom_range(0, 1) == 1));
                #1;
                if (prev_rv && !prev_rr && !prev_rst && !rst) begin
                    chk("rnd_hold_valid", r_valid, 1);
                    chk("rnd_hold_data", r_data, prev_rd);
                end
                if (rst) chk("rnd_rst_wready", w_ready, 0);
                if (cyc == 301) chk("rnd_rst_rvalid", r_valid, 0);
                if (cyc == 302) chk("rnd_post_rst_wready", w_ready, 1);
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
                chk("rnd_level", level, q.size());
`endif
                took_w = w_valid && w_ready;
                if (took_w) q.push_back(w_data);
                if (r_valid && r_ready) begin
                    chk("rnd_beat_expected", q.size() != 0, 1);
                    if (q.size() != 0) chk("rnd_order", r_data, q.pop_front());
                end
                if (rst) q.delete();
                prev_rv  = r_valid;
                prev_rr  = r_ready;
                prev_rst = rst;
                prev_rd  = r_data;
            end
            chk("rnd_drained", q.size(), 0);
            chk("rnd_idle", r_valid, 0);
            done = 1'b1;
        end
    end

    initial begin
        int          first_c, last_c, n_out, n_stall, n_acc;
        logic [15:0] exp_d;
        logic        all_done;

        rst_d = 1'b1;  flush_d = 1'b0;
        s7_w_valid = 0; s7_w_data = '0; s7_r_ready = 0;
        s3_w_valid = 0; s3_w_data = '0; s3_r_ready = 0;
        s2_w_valid = 0; s2_w_data = '0; s2_r_ready = 0;
        s0_w_valid = 0; s0_w_data = '0; s0_r_ready = 0;

        // reset
        @(negedge clk); #1;
        chk("rst_wready", s7_w_ready, 0);
        chk("rst_rvalid", s7_r_valid, 0);
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        chk("rst_level", s7_level, 0);
`endif
        @(negedge clk);
        rst_d = 1'b0;
        #1;
        chk("post_rst_wready_m7", s7_w_ready, 1);
        chk("post_rst_wready_m3", s3_w_ready, 1);

        // MODE 7 back-to-back burst 0x1..0x10
        s7_r_ready = 1'b1;
        first_c = -1; last_c = -1; n_out = 0; n_stall = 0; exp_d = 16'h1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            s7_w_valid = (c < 16);
            s7_w_data  = 16'(c + 1);
            #1;
            if (s7_w_valid && !s7_w_ready) n_stall++;
            if (s7_r_valid && s7_r_ready) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                chk("burst_data", s7_r_data, exp_d);
                exp_d++;
                n_out++;
            end
        end
        chk("burst_first_cycle", first_c, 2);
        chk("burst_last_cycle", last_c, 17);
        chk("burst_count", n_out, 16);
        chk("burst_stalls", n_stall, 0);

        // MODE 7 fill with r_ready low, then drain
        s7_r_ready = 1'b0; n_acc = 0; exp_d = 16'h20;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            s7_w_valid = 1'b1;
            s7_w_data  = 16'h20 + 16'(n_acc);
            #1;
            if (s7_w_ready) n_acc++;
        end
        chk("fill_accepted", n_acc, 4);
        chk("fill_wready", s7_w_ready, 0);
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        chk("fill_level", s7_level, 4);
`endif
        n_out = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            s7_w_valid = 1'b0;
            s7_r_ready = 1'b1;
            #1;
            if (s7_r_valid && s7_r_ready) begin
                chk("drain_data", s7_r_data, exp_d);
                exp_d++;
                n_out++;
            end
        end
        chk("drain_count", n_out, 4);

        // MODE 7 flush with 3 beats held
        s7_r_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s7_w_valid = 1'b1;
            s7_w_data  = 16'h30 + 16'(c);
            #1;
            chk("flush_fill_wready", s7_w_ready, 1);
        end
        @(negedge clk);
        s7_w_valid = 1'b0;
        flush_d    = 1'b1;
        #1;
        chk("flush_wready", s7_w_ready, 0);
        chk("flush_rvalid_held", s7_r_valid, 1);
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        chk("flush_level_before", s7_level, 3);
`endif
        @(negedge clk);
        flush_d = 1'b0;
        #1;
        chk("flush_rvalid", s7_r_valid, 0);
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        chk("flush_level", s7_level, 0);
`endif
        first_c = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            s7_w_valid = (c == 0);
            s7_w_data  = 16'hA5;
            s7_r_ready = 1'b1;
            #1;
            if (c == 0) chk("flush_next_wready", s7_w_ready, 1);
            if (s7_r_valid && s7_r_ready && first_c < 0) begin
                first_c = c;
                chk("flush_next_data", s7_r_data, 16'hA5);
            end
        end
        chk("flush_next_latency", first_c, 2);

        // MODE 3: one beat every two cycles
        s3_r_ready = 1'b1; n_out = 0; n_acc = 0; exp_d = 16'h40;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            s3_w_valid = 1'b1;
            s3_w_data  = 16'h40 + 16'(n_acc);
            #1;
            chk("lite_wready_toggle", s3_w_ready, (c % 2 == 0));
            if (s3_w_ready) n_acc++;
            if (s3_r_valid && s3_r_ready) begin
                chk("lite_data", s3_r_data, exp_d);
                exp_d++;
                n_out++;
            end
        end
        chk("lite_count", n_out, 5);
        @(negedge clk);
        s3_w_valid = 1'b0;

        // MODE 2: pass-through, then skid capture
        s2_r_ready = 1'b1; s2_w_valid = 1'b1; s2_w_data = 16'h5A5A;
        #1;
        chk("rev_pass_valid", s2_r_valid, 1);
        chk("rev_pass_data", s2_r_data, 16'h5A5A);
        chk("rev_pass_wready", s2_w_ready, 1);
        @(negedge clk);
        s2_w_data = 16'h1234; s2_r_ready = 1'b0;
        #1;
        chk("rev_stall_wready", s2_w_ready, 1);
        @(negedge clk);
        s2_w_valid = 1'b0;
        #1;
        chk("rev_skid_wready", s2_w_ready, 0);
        chk("rev_skid_valid", s2_r_valid, 1);
        chk("rev_skid_data", s2_r_data, 16'h1234);
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        chk("rev_skid_level", s2_level, 1);
`endif
        @(negedge clk);
        s2_r_ready = 1'b1;
        #1;
        chk("rev_skid_out_valid", s2_r_valid, 1);
        chk("rev_skid_out_data", s2_r_data, 16'h1234);
        @(negedge clk);
        #1;
        chk("rev_empty_wready", s2_w_ready, 1);
        chk("rev_empty_valid", s2_r_valid, 0);

        // MODE 0: wires
        @(negedge clk);
        s0_w_valid = 1'b1; s0_w_data = 16'h0F0F; s0_r_ready = 1'b0;
        #1;
        chk("wire_valid", s0_r_valid, 1);
        chk("wire_data", s0_r_data, 16'h0F0F);
        chk("wire_ready_lo", s0_w_ready, 0);
        s0_w_valid = 1'b0; s0_r_ready = 1'b1;
        #1;
        chk("wire_valid_lo", s0_r_valid, 0);
        chk("wire_ready_hi", s0_w_ready, 1);
`ifdef STREAM_SLICE_PIPE_LEVEL_EN
        chk("wire_level", s0_level, 0);
`endif

        all_done = 1'b0;
        for (int t = 0; t < 5000 && !all_done; t++) begin
            @(negedge clk);
            all_done = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done &&
                       g_rnd[3].done && g_rnd[4].done && g_rnd[5].done;
        end
        chk("rnd_done", all_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
